// File: rtl/post_addsub_acc_pipe.sv
// rtl/post_addsub_acc_pipe.sv - DSP48A1-style post-adder/subtractor with accumulate, P/carry pipelines, valid and sticky overflow
module post_addsub_acc_pipe #(
  parameter int WIDTH       = 48,
  parameter int PDEPTH      = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] z_in,
  input  logic             cin,
  input  logic             sub,
  input  logic             acc_en,
  input  logic             in_valid,
  input  logic             ce_p,
  input  logic             rst_p,
  input  logic             ce_carry,
  input  logic             rst_carry,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] PCOUT,
  output logic             CARRYOUT,
  output logic             CARRYOUTF,
  output logic             out_valid,
  output logic             ovf
);

  logic [WIDTH-1:0] w_fb;
  logic [WIDTH-1:0] w_zop;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_xc;
  logic             w_carry;
  logic             w_v;
  logic             w_set;
  logic             r_ovf;

  assign w_zop = (acc_en && PDEPTH >= 1) ? w_fb : z_in;
  assign w_xc  = {1'b0, x_in} + {{WIDTH{1'b0}}, cin};

  // In WIDTH+1 bits the top bit is the carry for add and the unsigned borrow for subtract.
  always_comb begin
    w_sum = '0;
    if (sub) w_sum = {1'b0, w_zop} - w_xc;
    else     w_sum = {1'b0, w_zop} + w_xc;
  end

  assign w_r     = w_sum[WIDTH-1:0];
  assign w_carry = w_sum[WIDTH];

  always_comb begin
    w_v = 1'b0;
    if (sub) w_v = (w_zop[WIDTH-1] != x_in[WIDTH-1]) && (w_r[WIDTH-1] != w_zop[WIDTH-1]);
    else     w_v = (w_zop[WIDTH-1] == x_in[WIDTH-1]) && (w_r[WIDTH-1] != w_zop[WIDTH-1]);
  end

  generate
    if (PDEPTH == 0) begin : g_comb
      assign w_fb      = '0;
      assign P         = w_r;
      assign out_valid = in_valid;
      assign CARRYOUT  = w_carry;
    end else begin : g_pipe
      logic [WIDTH-1:0]  r_p [PDEPTH];
      logic [PDEPTH-1:0] r_v;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PDEPTH; i++) r_p[i] <= '0;
          r_v <= '0;
        end else if (rst_p) begin
          for (int i = 0; i < PDEPTH; i++) r_p[i] <= '0;
          r_v <= '0;
        end else if (ce_p) begin
          r_p[0] <= w_r;
          r_v[0] <= in_valid;
          for (int i = 1; i < PDEPTH; i++) begin
            r_p[i] <= r_p[i-1];
            r_v[i] <= r_v[i-1];
          end
        end
      end

      // Feedback from stage 1 keeps one accumulation per enabled cycle at any depth.
      assign w_fb      = r_p[0];
      assign P         = r_p[PDEPTH-1];
      assign out_valid = r_v[PDEPTH-1];

      if (CARRYOUTREG == 1) begin : g_creg
        logic [PDEPTH-1:0] r_c;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_c <= '0;
          end else if (rst_carry) begin
            r_c <= '0;
          end else if (ce_carry) begin
            r_c[0] <= w_carry;
            for (int i = 1; i < PDEPTH; i++) r_c[i] <= r_c[i-1];
          end
        end

        assign CARRYOUT = r_c[PDEPTH-1];
      end else begin : g_ccomb
        assign CARRYOUT = w_carry;
      end
    end
  endgenerate

  assign w_set = ce_p && in_valid && w_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_set)   r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign PCOUT     = P;
  assign CARRYOUTF = CARRYOUT;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_post_addsub_acc_pipe.sv
// tb/tb_post_addsub_acc_pipe.sv - directed bench for post_addsub_acc_pipe at PDEPTH=2 and PDEPTH=0
module tb_post_addsub_acc_pipe;

  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] x_in, z_in;
  logic         cin, sub, acc_en, in_valid, ce_p, rst_p, ce_carry, rst_carry, ovf_clr;

  logic [W-1:0] p2, pc2, p0, pc0;
  logic         co2, cof2, ov2, ovf2;
  logic         co0, cof0, ov0, ovf0;

  int n_pass = 0;
  int n_total = 0;

  post_addsub_acc_pipe #(.WIDTH(W), .PDEPTH(2), .CARRYOUTREG(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .z_in(z_in), .cin(cin), .sub(sub),
    .acc_en(acc_en), .in_valid(in_valid), .ce_p(ce_p), .rst_p(rst_p),
    .ce_carry(ce_carry), .rst_carry(rst_carry), .ovf_clr(ovf_clr),
    .P(p2), .PCOUT(pc2), .CARRYOUT(co2), .CARRYOUTF(cof2), .out_valid(ov2), .ovf(ovf2)
  );

  post_addsub_acc_pipe #(.WIDTH(W), .PDEPTH(0), .CARRYOUTREG(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .z_in(z_in), .cin(cin), .sub(sub),
    .acc_en(acc_en), .in_valid(in_valid), .ce_p(ce_p), .rst_p(rst_p),
    .ce_carry(ce_carry), .rst_carry(rst_carry), .ovf_clr(ovf_clr),
    .P(p0), .PCOUT(pc0), .CARRYOUT(co0), .CARRYOUTF(cof0), .out_valid(ov0), .ovf(ovf0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; x_in = '0; z_in = '0; cin = 0; sub = 0; acc_en = 0; in_valid = 0;
    ce_p = 0; rst_p = 0; ce_carry = 0; rst_carry = 0; ovf_clr = 0;
    #2;
    chk("reset_P", p2, 0);
    chk("reset_PCOUT", pc2, 0);
    chk("reset_CO", {co2, cof2}, 0);
    chk("reset_valid", ov2, 0);
    chk("reset_ovf", ovf2, 0);
    tick();
    rst_n = 1'b1;

    // add 10+5+1, latency 2 on dut2, combinational on dut0
    x_in = 48'd5; z_in = 48'd10; cin = 1; in_valid = 1; ce_p = 1; ce_carry = 1;
    #1;
    chk("d0_add_P", p0, 16);
    chk("d0_add_PCOUT", pc0, 16);
    chk("d0_add_valid", ov0, 1);
    chk("d0_add_CO", co0, 0);
    tick();
    chk("add_valid_lat1", ov2, 0);
    in_valid = 0;
    tick();
    chk("add_P", p2, 16);
    chk("add_CO", co2, 0);
    chk("add_valid_lat2", ov2, 1);
    tick();
    chk("add_valid_drop", ov2, 0);

    // subtract with and without borrow
    sub = 1; z_in = 48'd3; x_in = 48'd5; cin = 0; in_valid = 1;
    #1;
    chk("d0_sub_P", p0, 48'hFFFF_FFFF_FFFE);
    chk("d0_sub_CO", co0, 1);
    tick(); tick();
    chk("sub_borrow_P", p2, 48'hFFFF_FFFF_FFFE);
    chk("sub_borrow_CO", co2, 1);
    chk("sub_borrow_COF", cof2, 1);
    z_in = 48'd5; x_in = 48'd3;
    tick(); tick();
    chk("sub_P", p2, 2);
    chk("sub_CO", co2, 0);
    chk("sub_no_ovf", ovf2, 0);

    // accumulate from a cleared stage 1
    sub = 0; in_valid = 0; rst_p = 1;
    tick();
    rst_p = 0;
    chk("rstp_P", p2, 0);
    acc_en = 1; x_in = 48'd7; z_in = 48'd99; cin = 0;
    tick();
    chk("acc_c1_P", p2, 0);
    tick();
    chk("acc_c2_P", p2, 7);
    tick();
    chk("acc_c3_P", p2, 14);
    tick();
    chk("acc_c4_P", p2, 21);
    ce_p = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("acc_hold_P", p2, 21);
    end
    ce_p = 1;
    tick();
    chk("acc_after_hold_P", p2, 28);
    acc_en = 0; x_in = '0; z_in = '0;
    tick();
    chk("acc_next_P", p2, 35);

    // sticky overflow
    x_in = 48'h7FFF_FFFF_FFFF; z_in = 48'd1; in_valid = 1;
    #1;
    chk("ovf_before", ovf2, 0);
    tick();
    chk("ovf_set", ovf2, 1);
    in_valid = 0;
    tick();
    chk("ovf_sticky", ovf2, 1);
    chk("ovf_P", p2, 48'h8000_0000_0000);
    in_valid = 1; ovf_clr = 1;
    tick();
    chk("ovf_set_wins", ovf2, 1);
    in_valid = 0;
    tick();
    chk("ovf_cleared", ovf2, 0);
    ovf_clr = 0;

    // carry wrap, aligned with P, then hold with ce_carry=0
    x_in = 48'hFFFF_FFFF_FFFF; z_in = 48'd1; in_valid = 1;
    tick();
    chk("wrap_c1_P", p2, 48'h8000_0000_0000);
    chk("wrap_c1_CO", co2, 0);
    tick();
    chk("wrap_P", p2, 0);
    chk("wrap_CO", co2, 1);
    ce_carry = 0; x_in = 48'd5; z_in = 48'd10; cin = 1;
    tick(); tick();
    chk("chold_P", p2, 16);
    chk("chold_CO", co2, 1);
    rst_carry = 1;
    tick();
    rst_carry = 0;
    chk("rst_carry_CO", co2, 0);
    chk("rst_carry_P", p2, 16);
    ce_carry = 1;

    // async reset with a full pipeline, then sync rst_p while ce_p is low
    tick(); tick();
    chk("full_valid", ov2, 1);
    rst_n = 0;
    #1;
    chk("async_P", p2, 0);
    chk("async_PCOUT", pc2, 0);
    chk("async_valid", ov2, 0);
    rst_n = 1;
    tick(); tick();
    chk("reload_P", p2, 16);
    ce_p = 0; rst_p = 1;
    tick();
    rst_p = 0;
    chk("rstp_noce_P", p2, 0);
    chk("rstp_noce_valid", ov2, 0);

    // accumulation restarts from zero after async reset
    rst_n = 0;
    #1;
    rst_n = 1;
    acc_en = 1; x_in = 48'd7; cin = 0; z_in = 48'd50; ce_p = 1;
    tick(); tick();
    chk("acc_after_rst_P", p2, 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
